// File: rtl/lorenz_pkg.sv
// Shared types and helpers for the Lorenz state streamer.
// Provides the fixed-point widths, the sample-select encoding, the output FSM
// state type, the packed triplet payload and the quantise/saturate function.
package lorenz_pkg;

    localparam int unsigned STATE_W  = 27;
    localparam int unsigned FRAC_W   = 20;
    localparam int unsigned SAMPLE_W = 16;

    // Keep all integer bits of the state and as many fraction bits as fit.
    localparam int unsigned DEFAULT_SHIFT = FRAC_W - (SAMPLE_W - (STATE_W - FRAC_W));

    localparam logic signed [STATE_W-1:0] Q_MAX = 27'sd32767;
    localparam logic signed [STATE_W-1:0] Q_MIN = -27'sd32768;

    typedef enum logic [1:0] {
        SEL_X = 2'd0,
        SEL_Y = 2'd1,
        SEL_Z = 2'd2
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND_X = 2'd1,
        ST_SEND_Y = 2'd2,
        ST_SEND_Z = 2'd3
    } state_e;

    // One buffered sample triplet; x occupies the most significant bits.
    typedef struct packed {
        logic [SAMPLE_W-1:0] x;
        logic [SAMPLE_W-1:0] y;
        logic [SAMPLE_W-1:0] z;
    } triplet_t;

    localparam int unsigned TRIPLET_W = $bits(triplet_t);

    // Arithmetic shift then clamp into the signed 16-bit sample range.
    function automatic logic [SAMPLE_W-1:0] quantise(
        input logic signed [STATE_W-1:0] v,
        input int unsigned               shift
    );
        logic signed [STATE_W-1:0] q;
        q = v >>> shift;
        if (q > Q_MAX) begin
            return 16'h7FFF;
        end else if (q < Q_MIN) begin
            return 16'h8000;
        end
        return SAMPLE_W'(q);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
// Ports: CLOCK_50 clock; reset sync active-low; wr_en/wr_data write side
// (ignored when full); rd_en pop (ignored when empty); rd_data_c head entry;
// full/empty/level registered occupancy status.
module sync_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data_c,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr     = wr_en && !full;
    assign do_rd     = rd_en && !empty;
    assign rd_data_c = mem[rd_ptr];

    // Storage array carries no reset.
    always_ff @(posedge CLOCK_50) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10: begin
                    level <= level + LVL_W'(1);
                    full  <= (level == LVL_W'(DEPTH - 1));
                    empty <= 1'b0;
                end
                2'b01: begin
                    level <= level - LVL_W'(1);
                    full  <= 1'b0;
                    empty <= (level == LVL_W'(1));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lorenz_state_streamer.sv
// Decimates Lorenz x/y/z state updates, quantises them to 16-bit samples,
// buffers triplets and streams them out as x, y, z over valid/ready.
// Ports: CLOCK_50 clock; reset sync active-low; step_tick integrator update
// strobe; x_in/y_in/z_in signed 7.20 state; out_data/out_sel/out_valid/
// out_ready sample stream; fifo_level buffered triplets; drop_count
// saturating count of triplets lost to a full buffer.
module lorenz_state_streamer
    import lorenz_pkg::*;
#(
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SHIFT = DEFAULT_SHIFT
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        step_tick,
    input  logic [STATE_W-1:0]          x_in,
    input  logic [STATE_W-1:0]          y_in,
    input  logic [STATE_W-1:0]          z_in,
    output logic [SAMPLE_W-1:0]         out_data,
    output logic [1:0]                  out_sel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
    output logic [15:0]                 drop_count
);

    localparam int unsigned DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

    logic [DCNT_W-1:0] dcnt;
    logic              capture_c;
    logic              cap_valid;
    triplet_t          cap_data;
    triplet_t          fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    state_e            state;
    state_e            state_next;
    triplet_t          hold;
    triplet_t          hold_next;
    logic              pop_c;
    logic              fire_c;
    logic              valid_d;
    logic [1:0]        sel_d;
    logic [SAMPLE_W-1:0] data_d;

    assign capture_c = step_tick && (dcnt == DCNT_LAST);
    assign fire_c    = out_valid && out_ready;

    // Decimation counter and one-cycle capture register feeding the FIFO.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            dcnt      <= '0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= capture_c;
            if (step_tick) begin
                dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + DCNT_W'(1);
            end
            if (capture_c) begin
                cap_data.x <= quantise(x_in, SHIFT);
                cap_data.y <= quantise(y_in, SHIFT);
                cap_data.z <= quantise(z_in, SHIFT);
            end
        end
    end

    // A write arriving at a full FIFO is lost even if the FSM pops that edge.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (cap_valid && fifo_full && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    sync_fifo #(
        .WIDTH (TRIPLET_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .wr_en     (cap_valid),
        .wr_data   (cap_data),
        .rd_en     (pop_c),
        .rd_data_c (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // FSM state and holding register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state <= ST_IDLE;
            hold  <= '0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
        end
    end

    // Next state and FIFO pop; the last transfer of a triplet can pop the next.
    always_comb begin
        state_next = state;
        pop_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c      = 1'b1;
                    state_next = ST_SEND_X;
                end
            end
            ST_SEND_X: if (fire_c) state_next = ST_SEND_Y;
            ST_SEND_Y: if (fire_c) state_next = ST_SEND_Z;
            ST_SEND_Z: begin
                if (fire_c) begin
                    if (!fifo_empty) begin
                        pop_c      = 1'b1;
                        state_next = ST_SEND_X;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        hold_next = pop_c ? fifo_rdata : hold;
    end

    // Output values for the upcoming state; registered below.
    always_comb begin
        valid_d = 1'b0;
        sel_d   = out_sel;
        data_d  = out_data;
        case (state_next)
            ST_SEND_X: begin
                valid_d = 1'b1;
                sel_d   = SEL_X;
                data_d  = hold_next.x;
            end
            ST_SEND_Y: begin
                valid_d = 1'b1;
                sel_d   = SEL_Y;
                data_d  = hold_next.y;
            end
            ST_SEND_Z: begin
                valid_d = 1'b1;
                sel_d   = SEL_Z;
                data_d  = hold_next.z;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_sel   <= SEL_X;
            out_data  <= '0;
        end else begin
            out_valid <= valid_d;
            out_sel   <= sel_d;
            out_data  <= data_d;
        end
    end

endmodule

// File: doc/lorenz_state_streamer.md
Name: lorenz_state_streamer

Overview:
Consumer side of the Lorenz integrator array.
- Samples the x/y/z state variables (27-bit signed 7.20) on the integrator update strobe, with decimation.
- Quantises each value to a 16-bit signed sample and buffers whole triplets in a FIFO.
- Streams the samples out one at a time (x, then y, then z) over a valid/ready handshake to the downstream DAC/VGA plot writer.

Parameters:
DECIM, 4, capture one triplet every DECIM step_tick pulses (legal range 1..256)
DEPTH, 16, FIFO depth in triplets (power of 2, minimum 2)
SHIFT, 11, arithmetic right shift applied to the 7.20 value before 16-bit saturation

Ports:
CLOCK_50      in   1   system clock
reset         in   1   synchronous, active-low reset
step_tick     in   1   one-cycle strobe, high on the cycle integrator outputs update (AnalogClock)
x_in          in   27  signed 7.20 state x
y_in          in   27  signed 7.20 state y
z_in          in   27  signed 7.20 state z
out_data      out  16  signed sample
out_sel       out  2   0=x, 1=y, 2=z; 3 never driven
out_valid     out  1   sample present
out_ready     in   1   consumer accepts
fifo_level    out  5   triplets currently buffered (0..DEPTH)
drop_count    out  16  triplets dropped while FIFO full, saturating

Behaviour:
- Reset (reset==0 at a CLOCK_50 edge) clears: decim counter, FIFO pointers and level, FSM to IDLE, out_valid=0, out_data=0, out_sel=0, drop_count=0. Any in-flight triplet is discarded, including a triplet mid-transfer.
- Decimation counter (0..DECIM-1) advances on each step_tick and wraps. A capture occurs on the step_tick where the counter equals DECIM-1. With DECIM=1, every tick captures.
- Quantise each value: q = in >>> SHIFT (arithmetic shift). Saturate to 0x7FFF / 0x8000 if q falls outside the 16-bit range. With SHIFT=11, no saturation is possible.
- Capture pipeline:
  - Cycle T (tick): the quantised triplet is registered.
  - Edge T+1: the triplet is written to the FIFO.
  - If the FIFO already holds DEPTH entries at that edge, the write is dropped and drop_count increments, saturating at 0xFFFF.
  - A pop on the same cycle does not rescue a write to a full FIFO.
- FIFO: 48-bit entries {x,y,z}. A simultaneous write and pop on a non-full FIFO leaves fifo_level unchanged.
- Output FSM states: IDLE, SEND_X, SEND_Y, SEND_Z.
  - IDLE: if the FIFO is non-empty, pop into the holding register and go to SEND_X. out_valid rises on the next cycle.
  - Empty-FIFO latency: out_valid asserts 3 cycles after the capturing tick.
  - SEND_X/SEND_Y/SEND_Z: out_valid=1, out_sel=0/1/2, out_data = held x/y/z.
  - A transfer occurs when out_valid && out_ready at an edge. It advances X→Y→Z.
  - After the SEND_Z transfer: if the FIFO is non-empty, pop in the same edge and go directly to SEND_X (no bubble). Otherwise go to IDLE with out_valid=0.
- Handshake: while out_valid=1 and out_ready=0, out_data and out_sel hold stable. out_valid never drops without a transfer, except on reset.
- step_tick arriving while the FSM is stalled is unaffected; captures proceed into the FIFO independently.

Decomposition:
- Shared package lorenz_pkg:
  - STATE_W=27, FRAC_W=20, SAMPLE_W=16.
  - SEL_X/SEL_Y/SEL_Z encodings.
  - Quantise/saturate function.
- Sub-module sync_fifo:
  - Parameterised width and depth.
  - Synchronous active-low reset, full/empty/level outputs.
  - Write-on-full ignored.

Test Plan:
- DECIM=1, x=0x0100000 (1.0), y=-0x0200000 (-2.0), z=0x1980000 (25.5), out_ready=1, one tick → samples 0x0200 sel0, 0xFC00 sel1, 0x3300 sel2 on consecutive cycles; out_valid first high 3 cycles after tick.
- DECIM=4, 8 ticks with x incrementing by 0x0100000 per tick starting at 1.0 → exactly 2 triplets emitted, x samples 0x0800 and 0x1000.
- out_ready held 0, DEPTH=16, DECIM=1, 20 ticks → fifo_level=16 (one triplet held in FSM, so 17 stored), drop_count=3. out_data/out_sel stable throughout the stall.
- Random out_ready toggling over 1000 ticks → output sequence sel 0,1,2 repeating, no duplicates or losses vs. reference model when drop_count=0.
- reset asserted low for 1 cycle while in SEND_Y with 5 triplets queued → next cycle out_valid=0, fifo_level=0, drop_count=0; first tick after release (DECIM=1) yields a fresh x sample.
- SHIFT=8, x=0x3FFFFFF → out_data=0x7FFF; x=0x4000000 (most negative) → 0x8000.
